// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: branch opcodes, branch-predictor
// FSM states and the branch-offset sign-extension helper.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } bp_state_t;

    function automatic logic [XLEN-1:0] sext17(input logic [16:0] imm);
        return {{(XLEN-17){imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/bimodal_pht.sv
// Bimodal pattern history table: an array of 2-bit saturating counters with
// one read port (prediction) and one update port (resolution).
module bimodal_pht
    import cpu_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    // NOTE: every always_comb output gets its full default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            if (upd_taken && (ctr_q[upd_idx] != 2'b11)) begin
                ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
            end else if (!upd_taken && (ctr_q[upd_idx] != 2'b00)) begin
                ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
        end
    end

    // NOTE: the table is built from flops, not RAM, so it can take the async reset to weakly-not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Upper counter bit set means the counter is 2 or 3: predict taken.
    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/ifde_branch_ctrl.sv
// IF/DE pipeline register with decode-side bimodal branch prediction,
// single-outstanding-branch tracking and misprediction recovery.
module ifde_branch_ctrl
    import cpu_pkg::*;
#(
    parameter int N        = 32,
    parameter int PHT_BITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] if_instr,
    input  logic [N-1:0] if_pcinc4,
    input  logic         if_valid,
    input  logic         hz_stall,
    input  logic         ex_resolve,
    input  logic         ex_taken,
    output logic [N-1:0] id_instr,
    output logic [N-1:0] id_pcinc4,
    output logic         id_valid,
    output logic         BranchTaken,
    output logic [N-1:0] LastPC,
    output logic         Flush,
    output logic         stall_req
);

    bp_state_t           state_q, state_d;
    logic [N-1:0]        id_instr_q, id_instr_d;
    logic [N-1:0]        id_pcinc4_q, id_pcinc4_d;
    logic                id_valid_q, id_valid_d;
    logic                pend_pred_q, pend_pred_d;
    logic [PHT_BITS-1:0] pend_idx_q, pend_idx_d;
    logic [N-1:0]        pend_fall_q, pend_fall_d;
    logic [N-1:0]        pend_tgt_q, pend_tgt_d;
    logic                flush_q, flush_d;
    logic [N-1:0]        last_pc_q, last_pc_d;

    logic [5:0]          opcode;
    logic                is_branch;
    logic                dec_branch;
    logic [N-1:0]        bpc;
    logic [N-1:0]        target;
    logic [PHT_BITS-1:0] dec_idx;
    logic                pred_taken;
    logic                branch_taken;
    logic                stall;
    logic                issue;
    logic                resolve;
    logic                mispredict;

    assign opcode    = id_instr_q[31:26];
    assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    // A slot being squashed by a flush is wrong-path and must never issue.
    assign dec_branch = id_valid_q & is_branch & ~flush_q;

    assign bpc     = id_pcinc4_q - N'(4);
    assign target  = bpc + sext17(id_instr_q[16:0]);
    assign dec_idx = bpc[PHT_BITS+1:2];

    bimodal_pht #(
        .IDX_W(PHT_BITS)
    ) u_pht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (dec_idx),
        .rd_taken (pred_taken),
        .upd_en   (resolve),
        .upd_idx  (pend_idx_q),
        .upd_taken(ex_taken)
    );

    assign issue        = dec_branch & (state_q == IDLE) & ~hz_stall;
    assign branch_taken = issue & pred_taken;
    assign stall        = dec_branch & (state_q == PENDING);
    assign resolve      = ex_resolve & (state_q == PENDING);
    assign mispredict   = resolve & (ex_taken != pend_pred_q);

    always_comb begin
        state_d     = state_q;
        pend_pred_d = pend_pred_q;
        pend_idx_d  = pend_idx_q;
        pend_fall_d = pend_fall_q;
        pend_tgt_d  = pend_tgt_q;
        flush_d     = mispredict;
        last_pc_d   = last_pc_q;
        id_instr_d  = id_instr_q;
        id_pcinc4_d = id_pcinc4_q;
        id_valid_d  = id_valid_q;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d     = PENDING;
                    pend_pred_d = pred_taken;
                    pend_idx_d  = dec_idx;
                    pend_fall_d = id_pcinc4_q;
                    pend_tgt_d  = target;
                end
            end
            PENDING: begin
                if (resolve) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mispredict) begin
            last_pc_d = ex_taken ? pend_tgt_q : pend_fall_q;
        end

        // The slot after a redirect or flush is wrong-path: squash it, keep the fields.
        if (flush_q || branch_taken) begin
            id_valid_d = 1'b0;
        end else if (!(hz_stall || stall)) begin
            id_instr_d  = if_instr;
            id_pcinc4_d = if_pcinc4;
            id_valid_d  = if_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_instr_q  <= '0;
            id_pcinc4_q <= '0;
            id_valid_q  <= 1'b0;
            pend_pred_q <= 1'b0;
            pend_idx_q  <= '0;
            pend_fall_q <= '0;
            pend_tgt_q  <= '0;
            flush_q     <= 1'b0;
            last_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            id_instr_q  <= id_instr_d;
            id_pcinc4_q <= id_pcinc4_d;
            id_valid_q  <= id_valid_d;
            pend_pred_q <= pend_pred_d;
            pend_idx_q  <= pend_idx_d;
            pend_fall_q <= pend_fall_d;
            pend_tgt_q  <= pend_tgt_d;
            flush_q     <= flush_d;
            last_pc_q   <= last_pc_d;
        end
    end

    assign id_instr    = id_instr_q;
    assign id_pcinc4   = id_pcinc4_q;
    assign id_valid    = id_valid_q;
    assign BranchTaken = branch_taken;
    assign LastPC      = last_pc_q;
    assign Flush       = flush_q;
    assign stall_req   = stall;

endmodule

// File: doc/ifde_branch_ctrl.md
# ifde_branch_ctrl

IF/DE pipeline register with decode-side branch control for the 32-bit pipelined CPU. It captures the fetch stage's `Instruction` and `PCInc4` and presents them to decode. It predicts conditional branches with a 2-bit bimodal table and drives `BranchTaken` back to fetch. On a misprediction reported by execute, it issues the `Flush` and the recovery `LastPC` that fetch consumes.

## Interface
- N, 32, datapath/instruction width
- PHT_BITS, 4, log2 of prediction-table entries (16)

- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_instr  in  N  instruction from fetch
- if_pcinc4  in  N  PC+4 of that instruction
- if_valid  in  1  fetch slot holds a real instruction
- hz_stall  in  1  external hazard stall; hold IF/DE
- ex_resolve  in  1  execute resolves the outstanding branch this cycle
- ex_taken  in  1  actual branch outcome (valid with ex_resolve)
- id_instr  out  N  registered instruction to decode
- id_pcinc4  out  N  registered PC+4 to decode
- id_valid  out  1  decode slot valid
- BranchTaken  out  1  predict-taken redirect to fetch
- LastPC  out  N  recovery PC, valid while Flush=1
- Flush  out  1  misprediction flush to fetch
- stall_req  out  1  this block holds fetch (second branch while one is pending)

## Operation
- Branch decode: opcode = id_instr[31:26]; branch iff opcode is BEQ (6'b000100) or BNE (6'b000101). Offset = sign-extend(id_instr[16:0]) to N.
- Branch PC bpc = id_pcinc4 − 4. Target = bpc + offset. PHT index = bpc[PHT_BITS+1:2].
- PHT: 2^PHT_BITS 2-bit saturating counters. Predict taken iff counter ≥ 2. On resolve: +1 if taken, −1 if not. Saturates at 0 and 3.
- FSM states: IDLE, PENDING. Only one unresolved branch is allowed.
  - IDLE: a valid branch in decode issues. Capture {pred, idx, fallthrough=id_pcinc4, target} and go to PENDING.
  - PENDING with a valid branch in decode: stall_req=1. IF/DE holds and BranchTaken=0.
  - PENDING with ex_resolve=1: update PHT[idx] and go to IDLE.
    - Mispredict (ex_taken≠pred): next cycle Flush=1 and LastPC = ex_taken ? target : fallthrough.
- BranchTaken = id_valid & is_branch & pred_taken & (state==IDLE) & ~hz_stall. Combinational from registered state.
- IF/DE update each edge, in priority order:
  - Flush pending or BranchTaken: load id_valid=0. This squashes the wrong-path slot.
  - hz_stall | stall_req: hold all fields.
  - Otherwise: load if_instr, if_pcinc4, if_valid.
- A misprediction also clears any pending stall_req condition. The held decode branch is discarded by the flush.
- Resolve and a new decode branch in the same cycle: stall_req stays 1 that cycle. The new branch issues the next cycle if no flush occurs.
- ex_resolve in IDLE is ignored (no PHT update).

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - PHT entries 2'b01 (weakly not-taken).
  - Captured branch fields 0.
- IF→ID latency: 1 cycle.
- BranchTaken appears in the same cycle the branch sits in decode.
- Flush and LastPC: registered, high for exactly one cycle, the cycle after ex_resolve.
- PHT update takes effect at the edge ending the resolve cycle.
- rst_n low mid-operation: immediately clears the valid, state, Flush and PHT contents. No partial flush is emitted after release.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants OP_BEQ, OP_BNE
  - `bp_state_t` enum {IDLE, PENDING}
  - helper `sext17` (17→N sign extend)
- Sub-module `bimodal_pht` (counter array with read index, update index, update enable and taken; async reset to 2'b01).
- The IF/DE register and FSM live in the top module.

## Test plan
- Reset, then if_instr=32'h0000_0000 (non-branch) with if_pcinc4=32'h4 and if_valid=1 → next cycle id_instr=0, id_pcinc4=4, id_valid=1. BranchTaken=0 and Flush=0.
- BEQ at PC 0x100 with offset 17'h00010, cold PHT → BranchTaken=0. Then ex_resolve=1, ex_taken=1 → next cycle Flush=1, LastPC=0x110, and the following id_valid=0.
- Repeat the same BEQ taken twice → counter reaches 3. The third occurrence gives BranchTaken=1 in its decode cycle, and the next id_valid=0 (squash).
- Predicted-taken BEQ at 0x200 resolved not-taken → Flush=1 with LastPC=0x204, and PHT decrements to 2.
- Second BNE enters decode while a branch is PENDING → stall_req=1 and id_* held stable until resolve. With a correct prediction, the BNE issues one cycle after resolve.
- Negative offset 17'h1FFF0 at PC 0x300, actual taken after a not-taken prediction → LastPC=0x2F0. Assert rst_n=0 during PENDING → Flush never pulses.
